// File: rtl/apg_pkg.sv
// Shared definitions for the pattern-generator capture path: FSM state
// encoding, address-width helper and default bus/buffer sizes.
package apg_pkg;

  localparam int DEF_NUM_SIG  = 14;
  localparam int DEF_NUM_SAMP = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apg_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read-first
// read port. Only the read register is reset; the array holds its contents.
module apg_capture_ram
  import apg_pkg::*;
#(
  parameter  int NUM_SIG  = DEF_NUM_SIG,
  parameter  int NUM_SAMP = DEF_NUM_SAMP,
  localparam int ADDR_W   = addr_w(NUM_SAMP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [NUM_SIG-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [NUM_SIG-1:0] rdata
);

  logic [NUM_SIG-1:0] mem [NUM_SAMP];
  logic [NUM_SIG-1:0] rdata_d;
  logic [NUM_SIG-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive
  // a reset and stay readable afterwards.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  // NOTE: non-blocking assignments make the read sample the array before the
  // same-edge write lands, which is what gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apg_input_capture.sv
// Triggered capture of the DUT response bus into a sample buffer.
// Define APG_INPUT_CAPTURE_SYNC_EN to add a 2-flop synchronizer ahead of in_q.
module apg_input_capture
  import apg_pkg::*;
#(
  parameter  int NUM_SIG  = DEF_NUM_SIG,
  parameter  int NUM_SAMP = DEF_NUM_SAMP,
  parameter  int DECIM_W  = 16,
  localparam int ADDR_W   = addr_w(NUM_SAMP)
) (
  input  logic               wave_clk,
  input  logic               axi_resetn,
  input  logic [NUM_SIG-1:0] input_signals,
  input  logic               arm,
  input  logic               abort,
  input  logic [NUM_SIG-1:0] trig_mask,
  input  logic [NUM_SIG-1:0] trig_value,
  input  logic [ADDR_W:0]    capture_len,
  input  logic [DECIM_W-1:0] decim,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [NUM_SIG-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    sample_count
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(NUM_SAMP);
  localparam logic [ADDR_W:0] ONE_LEN  = (ADDR_W + 1)'(1);

  cap_state_e         state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [DECIM_W-1:0] dec_q, dec_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [DECIM_W-1:0] decim_cfg_q, decim_cfg_d;
  logic [NUM_SIG-1:0] mask_q, mask_d;
  logic [NUM_SIG-1:0] value_q, value_d;
  logic [NUM_SIG-1:0] in_q, in_d;

  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic               hit;
  logic [ADDR_W:0]    len_eff;
  logic [ADDR_W:0]    cnt_inc;

`ifdef APG_INPUT_CAPTURE_SYNC_EN
  logic [NUM_SIG-1:0] sync1_q, sync2_q;

  always_ff @(posedge wave_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= input_signals;
      sync2_q <= sync1_q;
    end
  end

  assign in_d = sync2_q;
`else
  assign in_d = input_signals;
`endif

  assign hit     = ((in_q ^ value_q) & mask_q) == '0;
  assign len_eff = ((capture_len == '0) || (capture_len > FULL_LEN)) ? FULL_LEN : capture_len;
  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    len_d       = len_q;
    decim_cfg_d = decim_cfg_q;
    mask_d      = mask_q;
    value_d     = value_q;
    we          = 1'b0;
    waddr       = cnt_q[ADDR_W-1:0];

    if (abort) begin
      // Abort wins over everything and blocks the write of this cycle.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d     = ST_ARMED;
            cnt_d       = '0;
            len_d       = len_eff;
            decim_cfg_d = decim;
            mask_d      = trig_mask;
            value_d     = trig_value;
          end
        end
        ST_ARMED: begin
          if (hit) begin
            we      = 1'b1;
            waddr   = '0;
            cnt_d   = ONE_LEN;
            dec_d   = decim_cfg_q;
            state_d = (len_q == ONE_LEN) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (dec_q == '0) begin
            we    = 1'b1;
            cnt_d = cnt_inc;
            dec_d = decim_cfg_q;
            if (cnt_inc == len_q) begin
              state_d = ST_DONE;
            end
          end else begin
            dec_d = dec_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wave_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dec_q       <= '0;
      len_q       <= '0;
      decim_cfg_q <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      in_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      len_q       <= len_d;
      decim_cfg_q <= decim_cfg_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      in_q        <= in_d;
    end
  end

  apg_capture_ram #(
    .NUM_SIG  (NUM_SIG),
    .NUM_SAMP (NUM_SAMP)
  ) u_ram (
    .clk   (wave_clk),
    .rst_n (axi_resetn),
    .we    (we),
    .waddr (waddr),
    .wdata (in_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_apg_input_capture.sv
// Randomized self-checking bench for apg_input_capture against a queue-based
// model of the capture rules; honours APG_INPUT_CAPTURE_SYNC_EN for latency.
module tb_apg_input_capture;

  localparam int NS  = 14;
  localparam int NP  = 128;
  localparam int DW  = 16;
  localparam int AW  = 7;
`ifdef APG_INPUT_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int P_IDLE = 0, P_ARMED = 1, P_CAP = 2, P_DONE = 3;

  logic          wave_clk = 1'b0;
  logic          axi_resetn;
  logic [NS-1:0] input_signals;
  logic          arm, abort;
  logic [NS-1:0] trig_mask, trig_value;
  logic [AW:0]   capture_len;
  logic [DW-1:0] decim;
  logic [AW-1:0] rd_addr;
  logic [NS-1:0] rd_data;
  logic          busy, done;
  logic [AW:0]   sample_count;

  apg_input_capture dut (
    .wave_clk      (wave_clk),
    .axi_resetn    (axi_resetn),
    .input_signals (input_signals),
    .arm           (arm),
    .abort         (abort),
    .trig_mask     (trig_mask),
    .trig_value    (trig_value),
    .capture_len   (capture_len),
    .decim         (decim),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count)
  );

  always #5 wave_clk = ~wave_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the capture is a list of stored samples; the buffer is
  // an array with per-address validity so unwritten words are never compared.
  int            m_phase;
  logic [NS-1:0] m_stored [$];
  logic [NS-1:0] m_mem    [NP];
  bit            m_valid  [NP];
  logic [NS-1:0] m_pipe   [$];
  int            m_len, m_decim, m_gap;
  logic [NS-1:0] m_mask, m_value;
  logic [NS-1:0] m_rd;
  bit            m_rd_known;
  int            in_mode;   // 0 ramp, 1 random, 2 hold

  task automatic model_reset();
    m_phase = P_IDLE;
    m_stored.delete();
    m_pipe.delete();
    for (int i = 0; i < LAT; i++) m_pipe.push_back('0);
    m_gap      = 0;
    m_len      = 0;
    m_decim    = 0;
    m_mask     = '0;
    m_value    = '0;
    m_rd       = '0;
    m_rd_known = 1'b1;
  endtask

  task automatic store(input logic [NS-1:0] v);
    m_mem[m_stored.size()]   = v;
    m_valid[m_stored.size()] = 1'b1;
    m_stored.push_back(v);
  endtask

  task automatic model_edge();
    logic [NS-1:0] cur;
    cur        = m_pipe[0];
    m_rd_known = m_valid[rd_addr];
    m_rd       = m_mem[rd_addr];
    if (abort) begin
      m_phase = P_IDLE;
    end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
      if (arm) begin
        m_stored.delete();
        m_len   = (capture_len == 0 || int'(capture_len) > NP) ? NP : int'(capture_len);
        m_decim = int'(decim);
        m_mask  = trig_mask;
        m_value = trig_value;
        m_phase = P_ARMED;
      end
    end else if (m_phase == P_ARMED) begin
      if ((cur & m_mask) == (m_value & m_mask)) begin
        store(cur);
        m_gap   = m_decim;
        m_phase = (m_len == 1) ? P_DONE : P_CAP;
      end
    end else begin
      if (m_gap == 0) begin
        store(cur);
        m_gap = m_decim;
        if (m_stored.size() == m_len) m_phase = P_DONE;
      end else begin
        m_gap--;
      end
    end
    m_pipe.push_back(input_signals);
    void'(m_pipe.pop_front());
  endtask

  task automatic tick();
    @(posedge wave_clk);
    model_edge();
    #1;
    check("busy", busy, (m_phase == P_ARMED || m_phase == P_CAP));
    check("done", done, (m_phase == P_DONE));
    check("sample_count", sample_count, m_stored.size());
    if (m_rd_known) check("rd_data", rd_data, m_rd);
    case (in_mode)
      0:       input_signals = input_signals + 1'b1;
      1:       input_signals = NS'($urandom);
      default: ;
    endcase
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      check("busy_done_excl", busy & done, 0);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic cfg(input logic [NS-1:0] mk, input logic [NS-1:0] vl,
                     input int len, input int dc);
    trig_mask   = mk;
    trig_value  = vl;
    capture_len = (AW + 1)'(len);
    decim       = DW'(dc);
  endtask

  initial begin
    logic [NS-1:0] saved0, old0, pat;
    logic [NS-1:0] exp_dec [3];
    int n;
    exp_dec[0] = 14'd5; exp_dec[1] = 14'd8; exp_dec[2] = 14'd11;

    for (int i = 0; i < NP; i++) m_valid[i] = 1'b0;
    axi_resetn = 1'b0;
    input_signals = '0; arm = 1'b0; abort = 1'b0; rd_addr = '0;
    in_mode = 0;
    cfg('0, '0, 4, 0);
    model_reset();
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", sample_count, 0);
    check("rst_rd_data", rd_data, 0);
    axi_resetn = 1'b1;

    // Immediate trigger, contiguous capture of a ramp.
    cfg('0, '0, 4, 0);
    pulse_arm();
    wait_done("t1_done", 20);
    check("t1_count", sample_count, 4);
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      tick();
      check("t1_consecutive", rd_data, m_stored[0] + NS'(i));
    end

    // Decimated capture starting on a masked value.
    in_mode = 2; input_signals = 14'h1000;
    repeat (LAT + 1) tick();
    cfg(14'h3FFF, 14'h0005, 3, 2);
    in_mode = 0; input_signals = '0;
    pulse_arm();
    wait_done("t2_done", 40);
    check("t2_count", sample_count, 3);
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(i);
      tick();
      check("t2_decim_buf", rd_data, exp_dec[i]);
    end

    // Length clipping: 0 and 200 both mean the full buffer.
    in_mode = 1;
    cfg('0, '0, 0, 0);
    pulse_arm();
    wait_done("t3a_done", 200);
    check("t3a_count", sample_count, NP);
    cfg('0, '0, 200, 0);
    pulse_arm();
    wait_done("t3b_done", 200);
    check("t3b_count", sample_count, NP);
    rd_addr = AW'(NP - 1);
    tick();
    tick();

    // Abort after 10 stored samples.
    cfg('0, '0, 64, 0);
    pulse_arm();
    n = 0;
    while (sample_count != 10 && n < 50) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_count", sample_count, 10);
    check("t4_idle", busy | done, 0);
    rd_addr = AW'(10);
    repeat (5) tick();
    check("t4_count_hold", sample_count, 10);

    // Arm and abort together: abort wins.
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    tick();
    check("t4b_idle", busy, 0);

    // Asynchronous reset between edges during a capture.
    in_mode = 0;
    cfg('0, '0, 64, 0);
    pulse_arm();
    repeat (6) tick();
    rd_addr = '0;
    tick();
    saved0 = m_mem[0];
    #3 axi_resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", sample_count, 0);
    check("arst_rd_data", rd_data, 0);
    model_reset();
    @(posedge wave_clk);
    @(negedge wave_clk);
    axi_resetn = 1'b1;
    tick();
    check("mem_not_reset", rd_data, saved0);

    // Trigger latency: one edge per pipeline stage, plus the write edge.
    in_mode = 2; input_signals = 14'h1555;
    cfg(14'h3FFF, 14'h2AAA, 1, 0);
    repeat (LAT + 1) tick();
    pulse_arm();
    repeat (2) tick();
    input_signals = 14'h2AAA;
    n = 0;
    while (sample_count == 0 && n < 10) begin tick(); n++; end
    check("trig_latency", n, LAT + 1);
    check("t6_done", done, 1);

    // Read-first on a same-address read and write.
    old0 = m_mem[0];
    pat  = ~old0;
    input_signals = pat;
    repeat (LAT + 1) tick();
    cfg('0, '0, 8, 0);
    rd_addr = '0;
    pulse_arm();
    tick();
    check("read_first_old", rd_data, old0);
    tick();
    check("read_first_new", rd_data, pat);
    wait_done("t7_done", 20);

    // Random traffic: stray arms/aborts, config changes mid-capture.
    in_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      arm   = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      trig_mask  = NS'($urandom & $urandom & $urandom);
      trig_value = NS'($urandom);
      capture_len = ($urandom_range(0, 9) == 0) ? (AW + 1)'(200) : (AW + 1)'($urandom_range(0, 12));
      decim   = DW'($urandom_range(0, 3));
      rd_addr = AW'($urandom_range(0, 15));
      tick();
    end
    arm = 1'b0; abort = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
